fir_coeff_loader: RTL and testbench

Upstream sequencer for the fir block. It takes a stream of coefficients over a valid/ready handshake and issues control-register writes to the FIR: one coefficient-clear command, then one store command per tap. While loading it freezes the FIR datapath. At the end it pulses the FIR accumulator clear, so filtering resumes on a clean pipeline with the new coefficient set.

---
 rtl/fir_coeff_loader_pkg.sv | 48 ++++
 rtl/fir_coeff_loader.sv | 145 ++++++++++++++
 tb/tb_fir_coeff_loader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_coeff_loader_pkg.sv
// Shared definitions for the FIR coefficient loader: control-word layout,
// opcodes, FSM state encoding and small helpers used by the loader.
package fir_coeff_loader_pkg;

    localparam int TAP_DEFAULT       = 32;
    localparam int DIM_COEFF_DEFAULT = 16;
    localparam int GAP_DEFAULT       = 2;
    localparam int CR_W              = 32;

    localparam logic [3:0] OP_CLR = 4'h1;
    localparam logic [3:0] OP_STO = 4'h2;

    localparam int COEFF_MSB = 31;
    localparam int COEFF_LSB = 16;
    localparam int IDX_MSB   = 15;
    localparam int IDX_LSB   = 8;
    localparam int OP_MSB    = 7;
    localparam int OP_LSB    = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FETCH = 3'd3,
        ST_WRITE = 3'd4,
        ST_FLUSH = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Assemble a FIR control word; the low nibble is reserved and always zero.
    function automatic logic [CR_W-1:0] make_cr(
        input logic [COEFF_MSB-COEFF_LSB:0] coeff,
        input logic [IDX_MSB-IDX_LSB:0]     idx,
        input logic [OP_MSB-OP_LSB:0]       op
    );
        logic [CR_W-1:0] cr;
        cr                    = '0;
        cr[COEFF_MSB:COEFF_LSB] = coeff;
        cr[IDX_MSB:IDX_LSB]     = idx;
        cr[OP_MSB:OP_LSB]       = op;
        return cr;
    endfunction

    function automatic logic n_taps_legal(input logic [7:0] n, input int tap);
        return (n != 8'd0) && (int'(n) <= tap);
    endfunction

endpackage

// File: rtl/fir_coeff_loader.sv
// Sequencer that streams a coefficient set into the FIR control register,
// freezing the FIR while loading and clearing its accumulators at the end.
module fir_coeff_loader
    import fir_coeff_loader_pkg::*;
#(
    parameter int TAP       = TAP_DEFAULT,
    parameter int DIM_COEFF = DIM_COEFF_DEFAULT,
    parameter int GAP       = GAP_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           n_taps,
    input  logic                 coeff_valid,
    input  logic [DIM_COEFF-1:0] coeff_data,
    output logic                 coeff_ready,
    output logic                 we_out,
    output logic [CR_W-1:0]      cr_out,
    output logic                 fir_stall,
    output logic                 fir_clr,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

    state_t          state_q, state_d;
    logic [7:0]      index_q, index_d;
    logic [7:0]      n_taps_q, n_taps_d;
    logic [3:0]      gap_cnt_q, gap_cnt_d;
    logic [CR_W-1:0] cr_q, cr_d;
    logic            we_q, we_d;
    logic            ready_q, ready_d;
    logic            stall_q, stall_d;
    logic            clr_q, clr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [7:0]      index_after;

    // Next-state logic; outputs below are derived from the state being entered
    // so that every output can come straight from a flop.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        n_taps_d    = n_taps_q;
        gap_cnt_d   = gap_cnt_q;
        cr_d        = cr_q;
        err_d       = 1'b0;
        index_after = index_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (n_taps_legal(n_taps, TAP)) begin
                        n_taps_d = n_taps;
                        index_d  = 8'd0;
                        cr_d     = make_cr(16'h0000, 8'h00, OP_CLR);
                        state_d  = ST_CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CLEAR, ST_WRITE: begin
                if (state_q == ST_WRITE) begin
                    index_after = index_q + 8'd1;
                end
                index_d   = index_after;
                gap_cnt_d = GAP_LOAD;
                if (GAP != 0) begin
                    state_d = ST_WAIT;
                end else if (index_after < n_taps_q) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_WAIT: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = (index_q < n_taps_q) ? ST_FETCH : ST_FLUSH;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            ST_FETCH: begin
                if (coeff_valid && ready_q) begin
                    cr_d    = make_cr(16'(coeff_data), index_q, OP_STO);
                    state_d = ST_WRITE;
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        we_d    = (state_d == ST_CLEAR) || (state_d == ST_WRITE);
        ready_d = (state_d == ST_FETCH);
        clr_d   = (state_d == ST_FLUSH);
        done_d  = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_DONE);
        stall_d = busy_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            index_q   <= 8'd0;
            n_taps_q  <= 8'd0;
            gap_cnt_q <= 4'd0;
            cr_q      <= '0;
            we_q      <= 1'b0;
            ready_q   <= 1'b0;
            stall_q   <= 1'b0;
            clr_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            n_taps_q  <= n_taps_d;
            gap_cnt_q <= gap_cnt_d;
            cr_q      <= cr_d;
            we_q      <= we_d;
            ready_q   <= ready_d;
            stall_q   <= stall_d;
            clr_q     <= clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign coeff_ready = ready_q;
    assign we_out      = we_q;
    assign cr_out      = cr_q;
    assign fir_stall   = stall_q;
    assign fir_clr     = clr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: a schedule-level model checked every
// cycle, plus literal write/done timings for each scenario.
module tb_fir_coeff_loader;
    import fir_coeff_loader_pkg::*;

    localparam int TAP = 32;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  n_taps = 8'd0;
    logic        coeff_valid = 1'b0;
    logic [15:0] coeff_data = 16'h0000;
    logic        coeff_ready, we_out, fir_stall, fir_clr, busy, done, err;
    logic [31:0] cr_out;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fir_coeff_loader #(.TAP(TAP), .DIM_COEFF(16), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .start(start), .n_taps(n_taps),
        .coeff_valid(coeff_valid), .coeff_data(coeff_data),
        .coeff_ready(coeff_ready), .we_out(we_out), .cr_out(cr_out),
        .fir_stall(fir_stall), .fir_clr(fir_clr), .busy(busy),
        .done(done), .err(err)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Model: tracks the load as a schedule (taps written, gap remaining)
    // and predicts the outputs of the cycle being entered at each edge.
    bit          chk_en = 0;
    bit          m_active = 0;
    int          m_k = 0, m_n = 0, m_wl = 0;
    logic        e_we = 0, e_ready = 0, e_stall = 0, e_clr = 0, e_busy = 0, e_done = 0, e_err = 0;
    logic [31:0] e_cr = 0;

    always @(posedge clk) begin : model
        logic p_ready, p_clr, p_done;
        p_ready = e_ready;
        p_clr   = e_clr;
        p_done  = e_done;
        e_we = 0; e_ready = 0; e_clr = 0; e_done = 0; e_err = 0;
        if (rst) begin
            chk_en   = 1;
            m_active = 0;
            e_cr     = 32'h0;
        end else if (m_active) begin
            if (p_done) m_active = 0;
            else if (p_clr) e_done = 1;
            else if (p_ready && coeff_valid) begin
                e_we = 1;
                e_cr = {coeff_data, 8'(m_k), 4'h2, 4'h0};
                m_k++;
                m_wl = GAP;
            end
            else if (p_ready) e_ready = 1;
            else if (m_wl > 0) m_wl--;
            else if (m_k < m_n) e_ready = 1;
            else e_clr = 1;
        end else if (start) begin
            if (n_taps >= 1 && n_taps <= TAP) begin
                m_active = 1;
                m_k = 0;
                m_n = int'(n_taps);
                m_wl = GAP;
                e_we = 1;
                e_cr = 32'h0000_0010;
            end else begin
                e_err = 1;
            end
        end
        e_busy  = m_active && !e_done;
        e_stall = e_busy;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_output("we_out", 32'(we_out), 32'(e_we));
            check_output("cr_out", cr_out, e_cr);
            check_output("coeff_ready", 32'(coeff_ready), 32'(e_ready));
            check_output("fir_stall", 32'(fir_stall), 32'(e_stall));
            check_output("fir_clr", 32'(fir_clr), 32'(e_clr));
            check_output("busy", 32'(busy), 32'(e_busy));
            check_output("done", 32'(done), 32'(e_done));
            check_output("err", 32'(err), 32'(e_err));
        end
    end

    // Event log relative to the start cycle, for the literal checks.
    int          cyc = 0, start_cyc = 0;
    int          we_rel[$];
    logic [31:0] we_cr[$];
    int          done_rel = -1, clr_rel = -1, err_cnt = 0, stall_cnt = 0;
    bit          hs_flag = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        hs_flag = coeff_valid && coeff_ready;
        if (we_out) begin
            we_rel.push_back(cyc - start_cyc);
            we_cr.push_back(cr_out);
        end
        if (done) done_rel = cyc - start_cyc;
        if (fir_clr) clr_rel = cyc - start_cyc;
        if (err) err_cnt++;
        if (fir_stall) stall_cnt++;
    end

    // Coefficient source: advances on each accepted handshake; can withhold
    // valid for a number of FETCH cycles in front of one chosen coefficient.
    bit          sup_en = 0;
    int          sup_idx = 0, hold_idx = -1, hold_left = 0;
    logic [15:0] coeff_tab [0:63];

    always begin
        @(posedge clk);
        #1;
        if (hs_flag) sup_idx++;
        if (sup_en && hold_left > 0 && sup_idx == hold_idx && coeff_ready) begin
            coeff_valid = 1'b0;
            hold_left--;
        end else begin
            coeff_valid = sup_en;
        end
        coeff_data = coeff_tab[sup_idx & 63];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        we_rel.delete();
        we_cr.delete();
        done_rel = -1;
        clr_rel = -1;
        err_cnt = 0;
        stall_cnt = 0;
    endtask

    task automatic apply_stimulus(input logic [7:0] n);
        clear_log();
        sup_idx = 0;
        start_cyc = cyc;
        start = 1'b1;
        n_taps = n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && done_rel < 0; i++) tick();
        check_output({name, " done seen"}, 32'(done_rel >= 0), 32'd1);
        tick();
        tick();
    endtask

    task automatic check_write(input string name, input int idx, input int rel, input logic [31:0] cr);
        check_output({name, " present"}, 32'(we_rel.size() > idx), 32'd1);
        if (we_rel.size() > idx) begin
            check_output({name, " time"}, 32'(we_rel[idx]), 32'(rel));
            check_output({name, " cr"}, we_cr[idx], cr);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check_output({name, " ctl"}, 32'({we_out, coeff_ready, fir_stall, fir_clr, busy, done, err}), 32'd0);
        check_output({name, " cr"}, cr_out, 32'h0);
    endtask

    task automatic check_nominal(input string name);
        check_output({name, " writes"}, 32'(we_rel.size()), 32'd4);
        check_write({name, " w0"}, 0, 1, 32'h0000_0010);
        check_write({name, " w1"}, 1, 5, 32'h1111_0020);
        check_write({name, " w2"}, 2, 9, 32'h2222_0120);
        check_write({name, " w3"}, 3, 13, 32'h3333_0220);
        check_output({name, " clr"}, 32'(clr_rel), 32'd16);
        check_output({name, " done"}, 32'(done_rel), 32'd17);
        check_output({name, " stall cycles"}, 32'(stall_cnt), 32'd16);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) coeff_tab[i] = 16'($urandom);
        sup_en = 1;

        // Reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom);
            n_taps = 8'($urandom_range(1, 32));
            tick();
            check_idle_outputs("reset");
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (3) tick();

        // Nominal load
        coeff_tab[0] = 16'h1111;
        coeff_tab[1] = 16'h2222;
        coeff_tab[2] = 16'h3333;
        apply_stimulus(8'd3);
        wait_done("nominal", 100);
        check_nominal("nominal");

        // Backpressure before the second coefficient
        hold_idx = 1;
        hold_left = 5;
        apply_stimulus(8'd3);
        wait_done("backpressure", 100);
        check_output("backpressure writes", 32'(we_rel.size()), 32'd4);
        check_write("backpressure w2", 2, 14, 32'h2222_0120);
        check_output("backpressure done", 32'(done_rel), 32'd22);
        hold_idx = -1;

        // Illegal lengths
        apply_stimulus(8'd0);
        repeat (3) tick();
        check_output("n0 err", 32'(err_cnt), 32'd1);
        check_output("n0 writes", 32'(we_rel.size()), 32'd0);
        apply_stimulus(8'd33);
        repeat (3) tick();
        check_output("n33 err", 32'(err_cnt), 32'd1);
        check_output("n33 writes", 32'(we_rel.size()), 32'd0);
        check_output("n33 stall", 32'(stall_cnt), 32'd0);

        // Start pulsed mid-load is ignored
        apply_stimulus(8'd3);
        repeat (5) tick();
        start = 1'b1;
        n_taps = 8'd5;
        tick();
        start = 1'b0;
        wait_done("restart", 100);
        check_nominal("restart");
        check_output("restart err", 32'(err_cnt), 32'd0);

        // Reset at cycle 7, then a single-tap load
        apply_stimulus(8'd3);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("midreset");
        tick();
        coeff_tab[0] = 16'hABCD;
        apply_stimulus(8'd1);
        wait_done("single", 100);
        check_output("single writes", 32'(we_rel.size()), 32'd2);
        check_write("single w0", 0, 1, 32'h0000_0010);
        check_write("single w1", 1, 5, 32'hABCD_0020);
        check_output("single done", 32'(done_rel), 32'd9);

        // Full length
        for (int k = 0; k < 32; k++) coeff_tab[k] = 16'(k + 1);
        apply_stimulus(8'd32);
        wait_done("full", 300);
        check_output("full writes", 32'(we_rel.size()), 32'd33);
        check_write("full last", 32, 129, 32'h0020_1F20);
        check_output("full done", 32'(done_rel), 32'd133);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
